// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ula arithmetic/logic unit.
// Holds the operation-code width, the op-code type and the named
// operation constants used by the interface, the core and the top.
package ula_pkg;

  localparam int ULA_OP_W = 4;

  typedef logic [ULA_OP_W-1:0] ula_op_t;

  localparam ula_op_t ULA_AND  = 4'b0000;
  localparam ula_op_t ULA_OR   = 4'b0001;
  localparam ula_op_t ULA_ADD  = 4'b0010;
  localparam ula_op_t ULA_XOR  = 4'b0011;
  localparam ula_op_t ULA_SLL  = 4'b0100;
  localparam ula_op_t ULA_SRL  = 4'b0101;
  localparam ula_op_t ULA_SUB  = 4'b0110;
  localparam ula_op_t ULA_SLT  = 4'b0111;
  localparam ula_op_t ULA_SLTU = 4'b1000;
  localparam ula_op_t ULA_SRA  = 4'b1001;
  localparam ula_op_t ULA_NOR  = 4'b1100;

endpackage

// File: rtl/ula_if.sv
// ula_if: operand/result bundle between the datapath and the ALU.
//   A, B   : operands (B also supplies the shift amount)
//   UlaOp  : operation select
//   S      : registered result
//   Zero   : registered flag, 1 when S is all zeros
// Handshake: there is none. Every rising clk edge samples A/B/UlaOp
// and updates S/Zero; the ALU is always ready and the inputs are
// always treated as valid.
// Modports: master drives the operands (datapath / bench),
//           slave is the ALU itself.
interface ula_if #(
  parameter int WIDTH = 32
);
  import ula_pkg::*;

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  ula_op_t          UlaOp;
  logic [WIDTH-1:0] S;
  logic             Zero;

  modport master (
    output A,
    output B,
    output UlaOp,
    input  S,
    input  Zero
  );

  modport slave (
    input  A,
    input  B,
    input  UlaOp,
    output S,
    output Zero
  );

endinterface

// File: rtl/ula_core.sv
// ula_core: purely combinational ALU function.
// Ports:
//   i_a, i_b  : operands
//   i_op      : operation select (ula_pkg constants)
//   o_result  : combinational result
//   o_zero    : 1 when o_result is all zeros
// Unassigned op codes produce 0 (and therefore o_zero = 1).
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  ula_op_t          i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero
);

  localparam int SHW = $clog2(WIDTH);

  // Only the low log2(WIDTH) bits of B select the shift distance.
  logic [SHW-1:0] w_shamt;
  logic           w_slt;
  logic           w_sltu;

  assign w_shamt = i_b[SHW-1:0];
  // True signed compare, so the answer stays right when A-B overflows.
  assign w_slt   = ($signed(i_a) < $signed(i_b));
  assign w_sltu  = (i_a < i_b);

  always_comb begin
    o_result = '0;
    case (i_op)
      ULA_AND:  o_result = i_a & i_b;
      ULA_OR:   o_result = i_a | i_b;
      ULA_ADD:  o_result = i_a + i_b;
      ULA_XOR:  o_result = i_a ^ i_b;
      ULA_SLL:  o_result = i_a << w_shamt;
      ULA_SRL:  o_result = i_a >> w_shamt;
      ULA_SUB:  o_result = i_a - i_b;
      ULA_SLT:  o_result = {{(WIDTH-1){1'b0}}, w_slt};
      ULA_SLTU: o_result = {{(WIDTH-1){1'b0}}, w_sltu};
      ULA_SRA:  o_result = WIDTH'($signed(i_a) >>> w_shamt);
      ULA_NOR:  o_result = ~(i_a | i_b);
      default:  o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/ula.sv
// ula: 32-bit arithmetic/logic unit with registered result.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (S=0, Zero=1 while high)
//   bus  : ula_if slave modport (A, B, UlaOp in; S, Zero out)
// Latency is one cycle: inputs sampled on a rising edge appear on
// S/Zero right after that edge and hold until the next one.
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  ula_if.slave bus
);

  logic [WIDTH-1:0] w_result;
  logic             w_zero;
  logic [WIDTH-1:0] r_s;
  logic             r_zero;

  ula_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_a      (bus.A),
    .i_b      (bus.B),
    .i_op     (bus.UlaOp),
    .o_result (w_result),
    .o_zero   (w_zero)
  );

  // Zero is registered from the same combinational result as S, so the
  // pair is always consistent; reset forces the all-zero state (Zero=1).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s    <= '0;
      r_zero <= 1'b1;
    end else begin
      r_s    <= w_result;
      r_zero <= w_zero;
    end
  end

  assign bus.S    = r_s;
  assign bus.Zero = r_zero;

endmodule

// File: tb/tb_ula.sv
module tb_ula;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  ula_if #(.WIDTH(32)) dut_if ();

  ula #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Written from the arithmetic meaning of each operation with 64-bit
  // integers: shifts as multiply/divide by powers of two, compares by
  // sign-bit reasoning.
  function automatic logic [31:0] ref_model(input logic [3:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned p;
    longint unsigned r;
    int sh;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b % 32);
    p  = 1;
    for (int i = 0; i < sh; i++) p = p * 2;
    r = 0;
    case (op)
      4'd0:  r = ua & ub;
      4'd1:  r = ua | ub;
      4'd2:  r = (ua + ub) % 64'h1_0000_0000;
      4'd3:  r = ua ^ ub;
      4'd4:  r = (ua * p) % 64'h1_0000_0000;
      4'd5:  r = ua / p;
      4'd6:  r = (ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000;
      4'd7: begin
        if (a[31] != b[31]) r = a[31] ? 1 : 0;
        else                r = (ua < ub) ? 1 : 0;
      end
      4'd8:  r = (ua < ub) ? 1 : 0;
      4'd9: begin
        // floor division of a negative value == complement trick
        if (a[31]) r = ({32'd0, ~a} / p) ^ 64'hFFFF_FFFF;
        else       r = ua / p;
      end
      4'd12: r = (ua | ub) ^ 64'hFFFF_FFFF;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // ---------------- scoreboard / checker ----------------
  task automatic check(input string tag, input logic [31:0] exp_s,
                       input logic exp_z);
    n_checks = n_checks + 1;
    assert (dut_if.S === exp_s && dut_if.Zero === exp_z)
      n_pass = n_pass + 1;
    else begin
      $display("FAIL %s: got S=%h Zero=%b, expected S=%h Zero=%b",
               tag, dut_if.S, dut_if.Zero, exp_s, exp_z);
      $error("comparison %s", tag);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    dut_if.UlaOp = op;
    dut_if.A     = a;
    dut_if.B     = b;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_s);
    drive(op, a, b);
    check(tag, exp_s, exp_s == 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rop;
    n_checks = 0;
    n_pass   = 0;

    // Reset asserted with ADD 20+12 present: output must be cleared
    // before any clock edge.
    rst          = 1'b1;
    dut_if.A     = 32'd20;
    dut_if.B     = 32'd12;
    dut_if.UlaOp = 4'b0010;
    #2;
    check("reset_async", 32'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", 32'd32, 1'b0);

    // Basic ops, A=20 B=12
    apply("and",      4'b0000, 32'd20, 32'd12, 32'd4);
    apply("or",       4'b0001, 32'd20, 32'd12, 32'd28);
    apply("add",      4'b0010, 32'd20, 32'd12, 32'd32);
    apply("sub",      4'b0110, 32'd20, 32'd12, 32'd8);
    apply("op1111",   4'b1111, 32'd20, 32'd12, 32'd0);
    apply("op1010",   4'b1010, 32'hFFFF_FFFF, 32'h1, 32'd0);
    apply("op1101",   4'b1101, 32'hFFFF_FFFF, 32'h0, 32'd0);

    // Wrap and Zero
    apply("add_wrap",     4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0);
    apply("add_ovf",      4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
    apply("sub_eq",       4'b0110, 32'd5, 32'd5, 32'd0);
    apply("sub_borrow",   4'b0110, 32'd0, 32'd1, 32'hFFFF_FFFF);

    // Compares
    apply("slt_neg",      4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
    apply("sltu_big",     4'b1000, 32'hFFFF_FFFF, 32'd1, 32'd0);
    apply("slt_ovf",      4'b0111, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
    apply("slt_false",    4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0);
    apply("sltu_true",    4'b1000, 32'd1, 32'hFFFF_FFFF, 32'd1);

    // Shifts
    apply("sll4",         4'b0100, 32'h8000_0010, 32'd4, 32'h0000_0100);
    apply("srl4",         4'b0101, 32'h8000_0010, 32'd4, 32'h0800_0001);
    apply("sra4",         4'b1001, 32'h8000_0010, 32'd4, 32'hF800_0001);
    apply("sll_hi_bits",  4'b0100, 32'h8000_0010, 32'h24, 32'h0000_0100);
    apply("sll0",         4'b0100, 32'h8000_0010, 32'h0, 32'h8000_0010);
    apply("sra31",        4'b1001, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
    apply("sra_pos",      4'b1001, 32'h4000_0000, 32'd30, 32'h0000_0001);

    // Logic
    apply("xor",          4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00);
    apply("nor",          4'b1100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h000F_000F);

    // Reset pulse mid-stream, between clock edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_async", 32'd0, 1'b1);
    @(posedge clk);
    #1;
    check("rst_mid_held", 32'd0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_release", 32'h000F_000F, 1'b0);

    // Randomized stimulus against the reference model
    for (int i = 0; i < 400; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = $urandom_range(0, 31) | ($urandom & 32'hFFFF_FFE0);
        2:       rb = ra ^ 32'h8000_0000;
        default: rb = $urandom;
      endcase
      apply($sformatf("rand_%0d_op%0d", i, rop), rop, ra, rb,
            ref_model(rop, ra, rb));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ula.md
Name: ula

Overview:
- 32-bit arithmetic/logic unit for the single-cycle RISC-V processor datapath.
- Operates on operands A and B, selected by the 4-bit operation code UlaOp.
- Result S and a zero flag are registered on the rising clock edge.
- Feeds the writeback/branch logic; the classic AND/OR/ADD/SUB encodings are preserved.

Parameters:
- WIDTH, 32, operand/result width in bits (shift amount uses the low log2(WIDTH) bits of B).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (shift amount source for shifts).
- UlaOp  input  4  operation select, encodings below.
- S  output  WIDTH  registered result.
- Zero  output  1  registered flag, 1 when the result being registered is all zeros.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: while rst=1, S=0 and Zero=1, immediately and independent of clk.
- Latency: 1 cycle. Inputs are sampled on the rising clk edge; S/Zero update on that edge and hold until the next edge.
- No handshake; a new operation is accepted every cycle.
- UlaOp encodings are literal 4-bit values, written MSB first:
  - 0000 AND: A & B
  - 0001 OR: A | B
  - 0010 ADD: A + B, modulo 2^WIDTH, carry discarded
  - 0011 XOR: A ^ B
  - 0100 SLL: A << B[4:0]
  - 0101 SRL: A >> B[4:0], logical
  - 0110 SUB: A - B, modulo 2^WIDTH, borrow discarded
  - 0111 SLT: 1 if signed(A) < signed(B), else 0; result zero-extended
  - 1000 SLTU: 1 if unsigned A < unsigned B, else 0
  - 1001 SRA: A >>> B[4:0], arithmetic, sign-filled
  - 1100 NOR: ~(A | B)
  - All other codes (1010, 1011, 1101, 1110, 1111): result 0, so Zero=1.
- Arithmetic rules:
  - No overflow or carry outputs; wrap-around is silent.
  - Examples: 0x7FFFFFFF+1 = 0x80000000; 0 - 1 = 0xFFFFFFFF.
  - SLT uses a true signed compare, not the SUB sign bit, so it is correct under overflow.
  - Shifts use only B[4:0]; upper bits of B are ignored. A shift of 0 returns A unchanged.
- Zero is computed from the same combinational result that is loaded into S in the same edge.
- Reset deasserting mid-stream: the first edge after deassertion registers the current inputs normally.
- Inputs containing X/Z propagate unspecified; no requirement.

Decomposition:
- Shared package holds:
  - ula_op constants: ULA_AND, ULA_OR, ULA_ADD, ULA_XOR, ULA_SLL, ULA_SRL, ULA_SUB, ULA_SLT, ULA_SLTU, ULA_SRA, ULA_NOR.
  - The 4-bit op width constant.
- One natural sub-module, ula_core: purely combinational function of A, B, UlaOp producing result and zero.
- The top level ula adds only the output register and reset.

Test Plan:
- Reset: assert rst with A=20, B=12, UlaOp=0010 -> S=0, Zero=1 immediately, without a clock edge. Deassert, one edge -> S=32, Zero=0.
- Basic ops with A=20, B=12, one edge each, each result visible the cycle after the inputs are applied:
  - 0000 -> S=4
  - 0001 -> S=28
  - 0010 -> S=32
  - 0110 -> S=8
  - 1111 -> S=0, Zero=1
- Wrap and Zero:
  - ADD 0xFFFFFFFF + 1 -> S=0, Zero=1
  - SUB 5 - 5 -> S=0, Zero=1
  - SUB 0 - 1 -> S=0xFFFFFFFF, Zero=0
- Compares, with A=0xFFFFFFFF (-1), B=1:
  - SLT -> 1
  - SLTU -> 0
  - With A=0x80000000, B=0x7FFFFFFF: SLT -> 1 (overflow case)
- Shifts, with A=0x80000010:
  - SLL with B=4 -> 0x00000100
  - SRL with B=4 -> 0x08000001
  - SRA with B=4 -> 0xF8000001
  - SLL with B=0x24 (uses 4) -> 0x00000100
- Logic, with A=0xF0F0F0F0, B=0x0FF00FF0:
  - XOR -> 0xFF00FF00
  - NOR -> 0x000F000F
  - rst pulse mid-stream -> S=0 asynchronously
